// File: rtl/img_pingpong_buf.sv
// Double-buffered frame store: writer fills one bank while the reader randomly reads the other completed bank.
// Read latency 1 clock; wr_ready drops while both banks hold unreleased frames and returns the cycle after rd_done.
module img_pingpong_buf #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DEPTH  = IMG_W * IMG_H,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_sof,
    output logic              o_wr_ready,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_done,
    output logic              o_frame_ready,
    output logic              o_wr_bank,
    output logic              o_rd_bank,
    output logic              o_addr_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [0:1][0:DEPTH-1];

    logic              r_wb;
    logic              r_rb;
    logic [1:0]        r_full;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_rd_vld;
    logic              r_rd_zero;
    logic [DATA_W-1:0] r_rd_q;
    logic              r_addr_err;

    logic              w_wr_acc;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_last;
    logic              w_rd_req;
    logic              w_rd_inrange;
    logic              w_release;
    logic [1:0]        w_full_nxt;

    assign o_wr_ready    = ~r_full[r_wb];
    assign o_frame_ready = r_full[r_rb];
    assign o_wr_bank     = r_wb;
    assign o_rd_bank     = r_rb;
    assign o_rd_valid    = r_rd_vld;
    assign o_addr_err    = r_addr_err;
    // r_rd_zero covers both the reset value and out-of-range reads without touching the RAM output register
    assign o_rd_data     = r_rd_zero ? '0 : r_rd_q;

    // a sof beat restarts the fill at pixel 0 of the current bank
    assign w_wr_acc     = i_wr_valid && o_wr_ready;
    assign w_wr_addr    = i_wr_sof ? '0 : r_waddr;
    assign w_wr_last    = (w_wr_addr == LAST_ADDR);

    assign w_rd_req     = i_rd_en && o_frame_ready;
    assign w_rd_inrange = ({1'b0, i_rd_addr} < DEPTH_EXT);
    assign w_release    = i_rd_done && o_frame_ready;

    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_wr_acc && w_wr_last) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wb][w_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rd_req && w_rd_inrange) begin
            r_rd_q <= r_mem[r_rb][i_rd_addr];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_full     <= 2'b00;
            r_waddr    <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_zero  <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_full   <= w_full_nxt;
            r_rd_vld <= w_rd_req;
            if (w_wr_acc) begin
                r_waddr <= w_wr_last ? '0 : (w_wr_addr + ADDR_W'(1));
                if (w_wr_last) begin
                    r_wb <= ~r_wb;
                end
            end
            if (w_release) begin
                r_rb <= ~r_rb;
            end
            if (w_rd_req) begin
                r_rd_zero <= ~w_rd_inrange;
                if (!w_rd_inrange) begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_img_pingpong_buf.sv
// Randomised directed bench for img_pingpong_buf against a frame-counting reference model.
module tb_img_pingpong_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 784;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_sof = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_done = 1'b0;
    logic              wr_ready, rd_valid, frame_ready, wr_bank, rd_bank, addr_err;
    logic [DATA_W-1:0] rd_data;

    img_pingpong_buf #(
        .DATA_W(DATA_W), .IMG_W(28), .IMG_H(28), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_wr_sof(wr_sof), .o_wr_ready(wr_ready),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .i_rd_done(rd_done), .o_frame_ready(frame_ready),
        .o_wr_bank(wr_bank), .o_rd_bank(rd_bank), .o_addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: frames are counted as written (nw) and released (nr); frame k lives in slot k%2.
    logic [7:0] frm [0:1][0:DEPTH-1];
    int         nw, nr, cur_len;
    logic [7:0] exp_rd;
    logic       exp_rv, exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        nw = 0; nr = 0; cur_len = 0;
        exp_rd = 8'h00; exp_rv = 1'b0; exp_err = 1'b0;
    endtask

    task automatic check_status();
        chk("wr_ready",    32'(wr_ready),    32'((nw - nr) < 2));
        chk("frame_ready", 32'(frame_ready), 32'((nw - nr) > 0));
        chk("wr_bank",     32'(wr_bank),     32'(nw % 2));
        chk("rd_bank",     32'(rd_bank),     32'(nr % 2));
        chk("rd_valid",    32'(rd_valid),    32'(exp_rv));
        chk("rd_data",     32'(rd_data),     32'(exp_rd));
        chk("addr_err",    32'(addr_err),    32'(exp_err));
    endtask

    task automatic cyc(input logic wv, input logic [7:0] wd, input logic sof,
                       input logic ren, input logic [ADDR_W-1:0] ra, input logic done);
        logic fr, rdy;
        wr_valid = wv; wr_data = wd; wr_sof = sof;
        rd_en = ren; rd_addr = ra; rd_done = done;
        fr  = (nw - nr) > 0;
        rdy = (nw - nr) < 2;
        @(posedge clk);
        #1;
        exp_rv = ren && fr;
        if (ren && fr) begin
            if (int'(ra) < DEPTH) begin
                exp_rd = frm[nr % 2][ra];
            end else begin
                exp_rd  = 8'h00;
                exp_err = 1'b1;
            end
        end
        if (wv && rdy) begin
            if (sof) cur_len = 0;
            frm[nw % 2][cur_len] = wd;
            cur_len++;
            if (cur_len == DEPTH) begin
                nw++;
                cur_len = 0;
            end
        end
        if (done && fr) nr++;
        check_status();
    endtask

    task automatic idle_or_read();
        cyc(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, DEPTH - 1)), 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        if ($urandom_range(0, 3) == 0) idle_or_read();
        cyc(1'b1, d, sof, 1'b0, '0, 1'b0);
    endtask

    task automatic rand_reads(input int n);
        for (int k = 0; k < n; k++) idle_or_read();
    endtask

    logic [7:0] e5;

    initial begin
        mreset();
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rst = 1'b0;

        // single frame with a repeating ramp
        for (int i = 0; i < DEPTH; i++) send(8'(i), i == 0);
        chk("t1_frame_ready", 32'(frame_ready), 32'd1);
        chk("t1_wr_bank", 32'(wr_bank), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 1'b0);
        chk("t1_rd0_valid", 32'(rd_valid), 32'd1);
        chk("t1_rd0_data", 32'(rd_data), 32'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd783, 1'b0);
        chk("t1_rd783_data", 32'(rd_data), 32'h0F);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("t1_rd_valid_drop", 32'(rd_valid), 32'd0);
        rand_reads(50);

        // second frame fills the other bank, then back-pressure
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0);
        chk("t2_wr_ready_low", 32'(wr_ready), 32'd0);
        repeat (5) cyc(1'b1, 8'hEE, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);
        chk("t2_wr_ready_back", 32'(wr_ready), 32'd1);
        chk("t2_rd_bank", 32'(rd_bank), 32'd1);
        chk("t2_frame_ready", 32'(frame_ready), 32'd1);
        rand_reads(100);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);

        // sof restart discards a partial fill
        repeat (100) send(8'hAA, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h55, i == 0);
            if (i == DEPTH - 2) chk("t3_not_ready_early", 32'(frame_ready), 32'd0);
        end
        chk("t3_frame_ready", 32'(frame_ready), 32'd1);
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'($urandom_range(0, DEPTH - 1)), 1'b0);
            chk("t3_rd_55", 32'(rd_data), 32'h55);
        end

        // out-of-range and no-frame reads
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd800, 1'b0);
        chk("t4_oob_valid", 32'(rd_valid), 32'd1);
        chk("t4_oob_data", 32'(rd_data), 32'h00);
        chk("t4_oob_err", 32'(addr_err), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd3, 1'b0);
        chk("t4_err_sticky", 32'(addr_err), 32'd1);
        chk("t4_inrange_after_oob", 32'(rd_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd3, 1'b0);
        chk("t4_noframe_valid", 32'(rd_valid), 32'd0);
        chk("t4_noframe_hold", 32'(rd_data), 32'h55);

        // asynchronous reset in the middle of a fill
        for (int i = 0; i < 400; i++) send(8'($urandom), i == 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        mreset();
        check_status();
        chk("t6_err_cleared", 32'(addr_err), 32'd0);
        chk("t6_wr_bank", 32'(wr_bank), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), i == 0);
        chk("t6_frame_ready", 32'(frame_ready), 32'd1);
        rand_reads(40);

        // release, read and final write beat on the same edge
        for (int i = 0; i < DEPTH - 1; i++) send(8'($urandom), i == 0);
        e5 = frm[0][5];
        cyc(1'b1, 8'h77, 1'b0, 1'b1, 10'd5, 1'b1);
        chk("t5_rd_data", 32'(rd_data), 32'(e5));
        chk("t5_rd_bank", 32'(rd_bank), 32'd1);
        chk("t5_frame_ready", 32'(frame_ready), 32'd1);
        chk("t5_wr_bank", 32'(wr_bank), 32'd0);
        chk("t5_wr_ready", 32'(wr_ready), 32'd1);
        rand_reads(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_pingpong_buf.md
Name: img_pingpong_buf

Overview:
- Parametrised double-buffered (ping-pong) image store between the pixel capture/downscale stream and the ANN inference engine.
- The writer streams one frame of IMG_W*IMG_H pixels into one bank while the ANN randomly reads the other completed bank.
- Successor to the fixed 784x8 single-bank image RAM: generic width/size, two banks, fill tracking, back-pressure, frame handoff.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 28: image width in pixels.
- IMG_H, 28: image height in pixels.
- DEPTH, IMG_W*IMG_H (784): pixels per frame, i.e. words per bank.
- ADDR_W, 10: pixel address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  single clock for all logic and both RAM ports.
- rst  in  1  asynchronous reset, active-high.
- wr_valid  in  1  pixel beat valid.
- wr_data  in  DATA_W  pixel value.
- wr_sof  in  1  start-of-frame, qualified with the accepted beat.
- wr_ready  out  1  writer may transfer.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  pixel address within the ready frame.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid.
- rd_done  in  1  consumer releases the current frame.
- frame_ready  out  1  a complete frame is readable.
- wr_bank  out  1  bank currently being filled.
- rd_bank  out  1  bank currently exposed to the reader.
- addr_err  out  1  sticky flag: out-of-range read occurred.

Behaviour:
Reset (async, rst=1):
- wb=0, rb=0, full[1:0]=0, waddr=0.
- wr_ready=1, frame_ready=0, rd_valid=0, rd_data=0, addr_err=0.
- RAM contents are not cleared.

Storage:
- 2*DEPTH x DATA_W inferred simple dual-port RAM, one write port and one read port, both on clk.
- Physical address = {bank, pixel address}.

Write side:
- wr_ready = !full[wb] (combinational from registers).
- A beat is accepted when wr_valid && wr_ready.
- Accepted beat without wr_sof: writes wr_data at {wb,waddr}, then waddr++.
- Accepted beat with wr_sof: writes at {wb,0} and sets waddr=1. This restarts a partial fill; the partial data is discarded.
- Accepted beat at waddr==DEPTH-1 (or a wr_sof beat when DEPTH==1): sets full[wb]=1, toggles wb, and sets waddr=0, all in the same edge.
- Beats with wr_ready=0 have no effect, including any wr_sof on them.
- wr_bank = wb.

Read side:
- frame_ready = full[rb]. rd_bank = rb.
- When rd_en && frame_ready && rd_addr<DEPTH: rd_data = RAM[{rb,rd_addr}] on the next edge, and rd_valid=1 for exactly that cycle. Latency is 1 clock.
- When rd_en && frame_ready && rd_addr>=DEPTH: rd_data=0, rd_valid=1 next cycle, and addr_err is set. addr_err clears only on reset.
- When rd_en && !frame_ready: ignored; rd_valid=0 next cycle and rd_data holds its last value.
- Back-to-back reads are allowed every cycle, for full throughput.

Handoff:
- rd_done && frame_ready: clears full[rb] and toggles rb on that edge.
- rd_done && !frame_ready: ignored.
- rd_en and rd_done in the same cycle: the read is served from the old rb; the release takes effect after it.
- rd_done on a bank and the final write beat on the other bank in the same cycle: both take effect. frame_ready stays 1, now pointing at the newly filled bank.
- A freshly released bank is writable the next cycle if wb points at it (wr_ready returns to 1).
- Write and read never hit the same bank in one cycle. When frame_ready=1, full[rb]=1 and so wb!=rb. No read-during-write collision handling is required.

Arithmetic:
- waddr is ADDR_W bits and never exceeds DEPTH-1.
- The bank bit is 1 bit and wraps 1->0.

Test Plan:
1. Single frame, defaults: stream 784 beats with values 0..255 repeating, wr_sof on beat 0. Required: frame_ready=1 the cycle after beat 783, wr_bank=1. Read addr 0 -> rd_data=0x00; addr 783 -> rd_data=0x0F; each rd_valid arrives 1 cycle later.
2. Back-pressure: stream 1568 beats with no rd_done. Required: wr_ready=0 after beat 1567 and further beats are ignored. Pulse rd_done -> wr_ready=1 next cycle, rd_bank=1, frame_ready=1, and the second frame reads back correctly.
3. SOF restart: write 100 beats of 0xAA, then wr_sof with 784 beats of 0x55. Required: frame_ready only after beat 784 of the restarted frame, and all reads return 0x55.
4. Out-of-range and no-frame reads: rd_addr=800 with a frame ready -> rd_valid=1, rd_data=0, addr_err=1 and sticky. rd_en with frame_ready=0 -> rd_valid stays 0.
5. Simultaneous events: bank 0 ready; in one cycle assert rd_done, rd_en(addr 5), and the last beat of bank 1. Required: rd_data = bank0[5], rd_bank=1, frame_ready stays 1, wr_bank=0, wr_ready=1.
6. Reset mid-fill: assert rst asynchronously after 400 beats. Required: outputs return to reset values immediately; a full new frame completes normally after rst deasserts.
